rv32i_dmem_resp: RTL and testbench
==================================

Name: rv32i_dmem_resp

Overview:
Data-memory responder for the rv32i core. It answers the core's load/store request port with a valid/ready handshake and a configurable wait-state count. It provides word-organised storage with byte write strobes, and flags misaligned or out-of-range accesses. It sits beside the core in the rv32i top level and is the target end of the core's data-bus initiator.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned)
WAIT_CYCLES, 1, extra cycles between request acceptance and response (0..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, lane-aligned
req_wstrb  input  4  byte enables for stores; ignored for loads
resp_valid  output  1  one-cycle pulse: response present
resp_rdata  output  32  load data (word); 0 for stores and errors
resp_err  output  1  access fault, qualified by resp_valid

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). Assertion takes effect immediately, independent of clk.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, goto WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: req_ready=0. Counter loads WAIT_CYCLES-1 at acceptance and decrements each cycle; goto RESP when it reads 0.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle; goto IDLE.
- Acceptance = rising edge with req_valid&&req_ready. At that edge, capture we/addr/wdata/wstrb and compute err.
- Error rule: err=1 if req_addr[1:0]!=0, or if (req_addr-BASE_ADDR) >= DEPTH_WORDS*4 (unsigned 32-bit subtraction, so addresses below base wrap and fault).
- Store commit: on the acceptance edge if !err. Byte i is written when req_wstrb[i]=1. wstrb=0 is legal: nothing written, resp_err=0.
- Load data is read on the acceptance edge and held in the response register. Word index = (req_addr-BASE_ADDR)>>2.
- Latency: resp_valid is high in cycle k+1+WAIT_CYCLES, where acceptance is the edge ending cycle k. req_ready returns to 1 the cycle after the response.
- Throughput: one transaction per WAIT_CYCLES+2 cycles. No backpressure on the response; the core must sample it in the pulse cycle.
- resp_rdata=0 and resp_err=0 whenever resp_valid=0. For stores, resp_rdata=0. For faults, resp_rdata=0 and resp_err=1.
- A load issued immediately after a store to the same word returns the post-store data. Stores commit before the next acceptance is possible.
- req_valid while not ready: ignored, and the request is not latched. The core must hold it until accepted.
- Reset mid-transaction: the transaction is abandoned and no response is issued. A store already accepted stays committed.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN=32
  - state enum (ST_IDLE, ST_WAIT, ST_RESP)
  - word-address helper constants
- One sub-module: rv32i_ram_be, a synchronous single-port word RAM with 4 byte-write enables and registered read. Not reset; DEPTH_WORDS parameter.
- The FSM, counter, address check and response register live in rv32i_dmem_resp.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 immediately.
- Full-word store then load (WAIT_CYCLES=1):
  - Store 0xDEADBEEF, wstrb=4'hF, addr 0x10 -> resp_valid pulse 2 cycles after acceptance, err=0, rdata=0.
  - Load addr 0x10 -> rdata=0xDEADBEEF.
- Byte strobes: store 0x11223344, wstrb=4'b0101, over 0xDEADBEEF at 0x10 -> load returns 0xDE22BE44.
- Faults:
  - Load addr 0x13 -> err=1, rdata=0.
  - Store to addr DEPTH_WORDS*4 -> err=1 and memory unchanged, checked by reading the last word.
- Latency sweep, WAIT_CYCLES=0 and 3:
  - resp_valid at exactly 1 and 4 cycles after acceptance.
  - req_ready low throughout; back-to-back requests accepted every 2 and 5 cycles.
- Reset abort: accept a load with WAIT_CYCLES=3, assert reset during WAIT -> no resp_valid pulse; the next request is accepted the cycle after reset deasserts.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ============================================================================
// rv32i_pkg
// Shared types and constants for the rv32i data-memory responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int WORD_BYTES = XLEN / 8;
  localparam int BYTE_OFF_W = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rv32i_ram_be.sv
// ============================================================================
// rv32i_ram_be
// Single-port word RAM with per-byte write enables and registered read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv32i_ram_be
  import rv32i_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [WORD_BYTES-1:0] wstrb_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [XLEN-1:0]       wdata_i,
  output logic [XLEN-1:0]       rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  // Read output only updates when enabled, so it holds through wait states.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (we_i && wstrb_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/rv32i_dmem_resp.sv
// ============================================================================
// rv32i_dmem_resp
// Data-memory responder: valid/ready request port, wait states, fault check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv32i_dmem_resp
  import rv32i_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [WORD_BYTES-1:0] req_wstrb,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic            err_q;

  logic [XLEN-1:0] off;
  logic            err;
  logic            accept;
  logic [XLEN-1:0] ram_rdata;

  // Below-base addresses wrap to huge offsets and fail the range test.
  assign off    = req_addr - BASE_ADDR;
  assign err    = (req_addr[BYTE_OFF_W-1:0] != '0) || ({1'b0, off} >= SPAN);
  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q  <= req_we;
        err_q <= err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Faulting accesses never touch the array, so out-of-range stores cannot alias.
  rv32i_ram_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .en_i    (accept && !err),
    .we_i    (req_we),
    .wstrb_i (req_wstrb),
    .addr_i  (off[AW+1:2]),
    .wdata_i (req_wdata),
    .rdata_o (ram_rdata)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_dmem_resp.sv
// ============================================================================
// tb_rv32i_dmem_resp
// Directed bench: three responders with WAIT_CYCLES = 0, 1 and 3.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rv32i_dmem_resp;

  logic        clk;
  logic        reset;
  logic        req_valid  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_wstrb  [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int chk_cnt;
  int pass_cnt;

  // d=0: WAIT_CYCLES=0, d=1: WAIT_CYCLES=1, d=2: WAIT_CYCLES=3
  for (genvar g = 0; g < 3; g++) begin : g_dut
    rv32i_dmem_resp #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_wstrb  (req_wstrb[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic chk_idle(input string tag, input int d);
    chk({tag, ".ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, ".valid"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, ".rdata"}, resp_rdata[d], 32'd0);
    chk({tag, ".err"}, 32'(resp_err[d]), 32'd0);
  endtask

  // One request on DUT d; checks acceptance, busy cycles, latency and response.
  task automatic txn(input int d, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] st, input int lat,
                     input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int  n;
    bit  seen;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_wstrb[d] = st;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      chk({tag, ".busy"}, 32'(req_ready[d]), 32'd0);
      if (resp_valid[d]) seen = 1'b1;
      else chk({tag, ".rd_idle"}, resp_rdata[d], 32'd0);
    end
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    chk({tag, ".rdata"}, resp_rdata[d], exp_rd);
    chk({tag, ".err"}, 32'(resp_err[d]), 32'(exp_err));
    @(negedge clk);
    chk_idle({tag, ".after"}, d);
  endtask

  // Hold req_valid high and record which cycles accept a request.
  task automatic thru(input int d, input int w, input string tag);
    int acc[$];
    int n;
    n = 3 * (w + 2);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = 1'b0;
    req_addr[d]  = 32'h0000_0010;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      if (req_ready[d]) acc.push_back(c);
    end
    req_valid[d] = 1'b0;
    chk({tag, ".count"}, 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      chk({tag, ".gap1"}, 32'(acc[1] - acc[0]), 32'(w + 2));
      chk({tag, ".gap2"}, 32'(acc[2] - acc[1]), 32'(w + 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
      req_wstrb[i] = 4'h0;
    end
    #3;
    for (int i = 0; i < 3; i++) chk_idle("reset", i);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Full-word store then load, WAIT_CYCLES=1
    txn(1, 1'b1, 32'h10,  32'hDEAD_BEEF, 4'hF, 2, 32'h0,         1'b0, "st_full");
    txn(1, 1'b0, 32'h10,  32'h0,         4'h0, 2, 32'hDEAD_BEEF, 1'b0, "ld_full");
    // Byte strobes on lanes 0 and 2
    txn(1, 1'b1, 32'h10,  32'h1122_3344, 4'h5, 2, 32'h0,         1'b0, "st_strb");
    txn(1, 1'b0, 32'h10,  32'h0,         4'h0, 2, 32'hDE22_BE44, 1'b0, "ld_strb");
    // Empty strobe writes nothing and is not a fault
    txn(1, 1'b1, 32'h10,  32'hFFFF_FFFF, 4'h0, 2, 32'h0,         1'b0, "st_nostrb");
    txn(1, 1'b0, 32'h10,  32'h0,         4'h0, 2, 32'hDE22_BE44, 1'b0, "ld_nostrb");
    // Faults
    txn(1, 1'b0, 32'h13,  32'h0,         4'h0, 2, 32'h0,         1'b1, "ld_misal");
    txn(1, 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF, 2, 32'h0,         1'b0, "st_last");
    txn(1, 1'b1, 32'h1000,32'h1234_5678, 4'hF, 2, 32'h0,         1'b1, "st_range");
    txn(1, 1'b0, 32'hFFC, 32'h0,         4'h0, 2, 32'hCAFE_F00D, 1'b0, "ld_last");
    txn(1, 1'b1, 32'h12,  32'h5555_5555, 4'hF, 2, 32'h0,         1'b1, "st_misal");
    txn(1, 1'b0, 32'h10,  32'h0,         4'h0, 2, 32'hDE22_BE44, 1'b0, "ld_after_misal");
    txn(1, 1'b0, 32'h1000,32'h0,         4'h0, 2, 32'h0,         1'b1, "ld_range");

    // Latency sweep
    txn(0, 1'b1, 32'h20,  32'hA5A5_0F0F, 4'hF, 1, 32'h0,         1'b0, "w0_st");
    txn(0, 1'b0, 32'h20,  32'h0,         4'h0, 1, 32'hA5A5_0F0F, 1'b0, "w0_ld");
    txn(2, 1'b1, 32'h20,  32'h0BAD_CAFE, 4'hF, 4, 32'h0,         1'b0, "w3_st");
    txn(2, 1'b0, 32'h20,  32'h0,         4'h0, 4, 32'h0BAD_CAFE, 1'b0, "w3_ld");

    // Back-to-back throughput
    thru(0, 0, "thru_w0");
    thru(2, 3, "thru_w3");
    repeat (2) @(negedge clk);

    // Reset abort during WAIT on the WAIT_CYCLES=3 responder
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 32'h20;
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    chk("abort.in_wait", 32'(req_ready[2]), 32'd0);
    #2 reset = 1'b1;
    #1 chk_idle("abort.async", 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort.no_resp", 32'(resp_valid[2]), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    txn(2, 1'b0, 32'h20,  32'h0,         4'h0, 4, 32'h0BAD_CAFE, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
